// File: rtl/htfab_pg_1x1.sv
// VGA 640x480@60 test-pattern generator for a 1x1 Tiny Tapeout tile.
// Eight selectable patterns on the TinyVGA PMOD pinout, output fully registered.
module htfab_pg_1x1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [9:0] H_VIS   = 10'd640;
    localparam logic [9:0] H_SYNC0 = 10'd656;
    localparam logic [9:0] H_SYNC1 = 10'd752;
    localparam logic [9:0] H_LAST  = 10'd799;
    localparam logic [9:0] V_VIS   = 10'd480;
    localparam logic [9:0] V_SYNC0 = 10'd490;
    localparam logic [9:0] V_SYNC1 = 10'd492;
    localparam logic [9:0] V_LAST  = 10'd524;
    localparam logic [9:0] BAR_END = 10'd636;
    localparam logic [5:0] WHITE   = 6'h3F;

    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [5:0] frame;
    logic [9:0] barx;
    logic [7:0] out_q;

    logic       visible;
    logic       hsync;
    logic       vsync;
    logic [2:0] k;
    logic       edge_px;
    logic [5:0] rgb;
    logic [7:0] pix;
    logic       frame_end;
    logic       advance;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, ui_in[6:3], uio_in};

    always_comb begin
        visible   = (hpos < H_VIS) && (vpos < V_VIS);
        hsync     = !((hpos >= H_SYNC0) && (hpos < H_SYNC1));
        vsync     = !((vpos >= V_SYNC0) && (vpos < V_SYNC1));
        frame_end = (hpos == H_LAST) && (vpos == V_LAST);
        advance   = frame_end && !ui_in[7];
        edge_px   = (hpos == 10'd0) || (hpos == 10'd639) ||
                    (vpos == 10'd0) || (vpos == 10'd479);

        // Colour-bar index hpos/80 as a threshold chain, avoiding a divider.
        k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hpos >= 10'(i * 80)) k = 3'(i);
        end

        rgb = 6'h00;
        case (ui_in[2:0])
            3'd0: rgb = {{2{~k[1]}}, {2{~k[2]}}, {2{~k[0]}}};
            3'd1: rgb = (hpos[5] ^ vpos[5]) ? WHITE : 6'h00;
            3'd2: rgb = {3{hpos[7:6]}};
            3'd3: rgb = ((hpos[4:0] == 5'd0) || (vpos[4:0] == 5'd0) ||
                         (hpos == 10'd639) || (vpos == 10'd479)) ? WHITE : 6'h00;
            3'd4: rgb = (hpos[8:3] ^ vpos[8:3]) + frame;
            3'd5: rgb = edge_px ? WHITE : 6'h00;
            3'd6: rgb = ((hpos >= barx) && (hpos < barx + 10'd16)) ? WHITE : 6'h00;
            default: rgb = WHITE;
        endcase
        if (!visible) rgb = 6'h00;

        // TinyVGA PMOD: {hsync,B0,G0,R0,vsync,B1,G1,R1}
        pix = {hsync, rgb[0], rgb[2], rgb[4], vsync, rgb[1], rgb[3], rgb[5]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos  <= 10'd0;
            vpos  <= 10'd0;
            frame <= 6'd0;
            barx  <= 10'd0;
            out_q <= 8'h88;
        end else begin
            out_q <= pix;
            if (hpos == H_LAST) begin
                hpos <= 10'd0;
                vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
            end else begin
                hpos <= hpos + 10'd1;
            end
            if (advance) begin
                frame <= frame + 6'd1;
                barx  <= (barx == BAR_END) ? 10'd0 : barx + 10'd4;
            end
        end
    end

    assign uo_out  = out_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_htfab_pg_1x1.sv
// Directed bench for htfab_pg_1x1: patterns, blanking, sync timing and animation.
// Long vertical distances are skipped by depositing the scan counters.
module tb_htfab_pg_1x1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests = 0;
    int fails = 0;
    int cur_x = 0;
    int cur_y = 0;
    int px = 0;
    int py = 0;
    logic [9:0] jx;
    logic [9:0] jy;

    htfab_pg_1x1 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock; px/py is the pixel now visible on uo_out, cur_x/cur_y the next one.
    task automatic step();
        px = cur_x;
        py = cur_y;
        @(posedge clk);
        if (!rst_n) begin
            cur_x = 0;
            cur_y = 0;
        end else if (cur_x == 799) begin
            cur_x = 0;
            cur_y = (cur_y == 524) ? 0 : cur_y + 1;
        end else begin
            cur_x = cur_x + 1;
        end
        #1;
    endtask

    task automatic show(input string tag, input int x, input int y);
        int n = 0;
        logic reached = 1'b0;
        while (!reached && n < 450000) begin
            step();
            n++;
            reached = (px == x) && (py == y);
        end
        check({tag, "_reach"}, {31'd0, reached}, 32'd1);
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic [7:0] exp);
        show(tag, x, y);
        check(tag, {24'd0, uo_out}, {24'd0, exp});
    endtask

    task automatic jump(input int x, input int y);
        jx = 10'(x);
        jy = 10'(y);
        force dut.hpos = jx;
        force dut.vpos = jy;
        #1;
        release dut.hpos;
        release dut.vpos;
        cur_x = x;
        cur_y = y;
    endtask

    task automatic next_frame();
        jump(799, 524);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        do_reset();
        check("rst_uo", {24'd0, uo_out}, 32'h88);
        check("rst_uio_out", {24'd0, uio_out}, 32'h00);
        check("rst_uio_oe", {24'd0, uio_oe}, 32'h00);

        // colour bars
        pix("bar_x0", 0, 0, 8'hFF);
        pix("bar_x100", 100, 0, 8'hBB);
        pix("bar_x160", 160, 0, 8'hEE);
        pix("bar_x400", 400, 0, 8'h99);
        pix("bar_x600", 600, 0, 8'h88);
        pix("hblank_655", 655, 0, 8'h88);
        pix("hsync_656", 656, 0, 8'h08);
        pix("hsync_751", 751, 0, 8'h08);
        pix("hsync_752", 752, 0, 8'h88);

        show("line_end", 799, 0);
        cnt = 0;
        repeat (800) begin
            step();
            if (uo_out[7] == 1'b0) cnt++;
        end
        check("hsync_low_per_line", cnt, 32'd96);

        ui_in = 8'h01;
        pix("chk_0_2", 0, 2, 8'h88);
        pix("chk_32_2", 32, 2, 8'hFF);
        jump(0, 32);
        pix("chk_0_32", 0, 32, 8'hFF);
        pix("chk_32_32", 32, 32, 8'h88);

        ui_in = 8'h02;
        jump(0, 33);
        pix("grey_64", 64, 33, 8'hF8);
        pix("grey_128", 128, 33, 8'h8F);
        pix("grey_200", 200, 33, 8'hFF);

        ui_in = 8'h03;
        jump(0, 34);
        pix("grid_0", 0, 34, 8'hFF);
        pix("grid_1", 1, 34, 8'h88);
        pix("grid_32", 32, 34, 8'hFF);
        pix("grid_638", 638, 34, 8'h88);
        pix("grid_639", 639, 34, 8'hFF);

        ui_in = 8'h04;
        jump(0, 64);
        pix("xor_8_64", 8, 64, 8'hCA);
        pix("xor_hblank", 700, 64, 8'h08);

        ui_in = 8'h05;
        jump(0, 65);
        pix("border_0", 0, 65, 8'hFF);
        pix("border_1", 1, 65, 8'h88);
        pix("border_639", 639, 65, 8'hFF);
        jump(0, 479);
        pix("border_479", 100, 479, 8'hFF);
        pix("vblank_480", 100, 480, 8'h88);

        ui_in = 8'h07;
        jump(0, 100);
        pix("solid", 10, 100, 8'hFF);
        pix("solid_hblank", 780, 100, 8'h88);
        jump(0, 489);
        pix("vs_489", 0, 489, 8'h88);
        pix("vs_490", 0, 490, 8'h80);
        pix("vs_both", 700, 490, 8'h00);
        pix("vs_491", 0, 491, 8'h80);
        pix("vs_492", 0, 492, 8'h88);

        jump(0, 488);
        cnt = 0;
        repeat (4800) begin
            step();
            if (uo_out[3] == 1'b0) cnt++;
        end
        check("vsync_low_clks", cnt, 32'd1600);

        // mid-frame reset, then animation
        ui_in = 8'h06;
        do_reset();
        check("rst2_uo", {24'd0, uo_out}, 32'h88);
        pix("mbar0_0", 0, 0, 8'hFF);
        pix("mbar0_15", 15, 0, 8'hFF);
        pix("mbar0_16", 16, 0, 8'h88);

        next_frame();
        next_frame();
        pix("mbar2_7", 7, 0, 8'h88);
        pix("mbar2_8", 8, 0, 8'hFF);
        pix("mbar2_23", 23, 0, 8'hFF);
        pix("mbar2_24", 24, 0, 8'h88);
        ui_in = 8'h04;
        pix("frame2", 0, 1, 8'h8C);

        ui_in = 8'h86;
        next_frame();
        next_frame();
        pix("frz_7", 7, 0, 8'h88);
        pix("frz_8", 8, 0, 8'hFF);
        pix("frz_24", 24, 0, 8'h88);
        ui_in = 8'h84;
        pix("frz_frame", 0, 1, 8'h8C);

        ui_in = 8'h06;
        repeat (157) next_frame();
        pix("mbar159_635", 635, 0, 8'h88);
        pix("mbar159_636", 636, 0, 8'hFF);
        pix("mbar159_639", 639, 0, 8'hFF);
        ui_in = 8'h04;
        pix("frame159", 0, 1, 8'hFE);

        ui_in = 8'h06;
        next_frame();
        pix("mbar_wrap_0", 0, 0, 8'hFF);
        pix("mbar_wrap_16", 16, 0, 8'h88);
        ui_in = 8'h04;
        pix("frame160", 0, 1, 8'h89);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
